// File: rtl/nec_ir_decoder.sv
// NEC infrared remote decoder: conditions the raw receiver pin, times marks and
// spaces in microsecond ticks and assembles 32-bit codes, flagging repeats and errors.
module nec_ir_decoder #(
    parameter int unsigned CLK_PER_US  = 74,
    parameter int unsigned FILT_CYCLES = 8,
    parameter bit          CHECK_INV   = 1'b1,
    // Divides every window and the timeout; must divide them evenly (1 = real NEC timing).
    parameter int unsigned TIME_DIV    = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        ir_raw_in,
    output logic [31:0] ir_out,
    output logic        valid_out,
    output logic        repeat_out,
    output logic        error_out
);

    localparam int unsigned DUR_W  = 14;
    localparam int unsigned PRE_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int unsigned FLT_W  = $clog2(FILT_CYCLES + 1);
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned CODE_W = 32;

    localparam logic [DUR_W-1:0] DUR_MAX   = '1;
    localparam logic [DUR_W-1:0] LEAD_MIN  = DUR_W'(8000 / TIME_DIV);
    localparam logic [DUR_W-1:0] LEAD_MAX  = DUR_W'(10000 / TIME_DIV);
    localparam logic [DUR_W-1:0] DSP_MIN   = DUR_W'(3500 / TIME_DIV);
    localparam logic [DUR_W-1:0] DSP_MAX   = DUR_W'(5500 / TIME_DIV);
    localparam logic [DUR_W-1:0] RSP_MIN   = DUR_W'(1750 / TIME_DIV);
    localparam logic [DUR_W-1:0] RSP_MAX   = DUR_W'(2750 / TIME_DIV);
    localparam logic [DUR_W-1:0] MARK_MIN  = DUR_W'(400 / TIME_DIV);
    localparam logic [DUR_W-1:0] MARK_MAX  = DUR_W'(750 / TIME_DIV);
    localparam logic [DUR_W-1:0] SP0_MIN   = DUR_W'(400 / TIME_DIV);
    localparam logic [DUR_W-1:0] SP0_MAX   = DUR_W'(750 / TIME_DIV);
    localparam logic [DUR_W-1:0] SP1_MIN   = DUR_W'(1400 / TIME_DIV);
    localparam logic [DUR_W-1:0] SP1_MAX   = DUR_W'(1950 / TIME_DIV);
    localparam logic [DUR_W-1:0] TIMEOUT   = DUR_W'(12000 / TIME_DIV);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CODE_W - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
    localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_MARK
    } state_t;

    state_t              state, state_nx;
    logic [1:0]          sync_q;
    logic                filt, filt_d, rise_q, fall_q;
    logic [FLT_W-1:0]    flt_cnt;
    logic [PRE_W-1:0]    pre;
    logic [DUR_W-1:0]    dur;
    logic [BIT_W-1:0]    bit_cnt;
    logic [CODE_W-1:0]   shreg;
    logic                have_code;

    logic lead_ok_c, dsp_ok_c, rsp_ok_c, mark_ok_c, sp0_ok_c, sp1_ok_c;
    logic timeout_c, last_bit_c, inv_ok_c;
    logic shift_c, clr_bits_c, valid_c, repeat_c, error_c;
    logic [CODE_W-1:0] shreg_nx_c;

    function automatic logic in_win(input logic [DUR_W-1:0] d,
                                    input logic [DUR_W-1:0] lo,
                                    input logic [DUR_W-1:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Two-flop synchronizer, idle-high
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], ir_raw_in};
    end

    // Glitch filter: level must disagree with filt for FILT_CYCLES in a row
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            filt    <= 1'b1;
            flt_cnt <= '0;
        end else if (sync_q[1] == filt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FLT_LAST) begin
            filt    <= sync_q[1];
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + FLT_W'(1);
        end
    end

    // Registered edge pulses on the filtered level
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            filt_d <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            filt_d <= filt;
            rise_q <= filt & ~filt_d;
            fall_q <= filt_d & ~filt;
        end
    end

    // Microsecond prescaler and saturating duration counter, restarted per edge
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pre <= '0;
            dur <= '0;
        end else if (rise_q || fall_q) begin
            pre <= '0;
            dur <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
            if (dur != DUR_MAX) dur <= dur + DUR_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    assign lead_ok_c  = in_win(dur, LEAD_MIN, LEAD_MAX);
    assign dsp_ok_c   = in_win(dur, DSP_MIN, DSP_MAX);
    assign rsp_ok_c   = in_win(dur, RSP_MIN, RSP_MAX);
    assign mark_ok_c  = in_win(dur, MARK_MIN, MARK_MAX);
    assign sp0_ok_c   = in_win(dur, SP0_MIN, SP0_MAX);
    assign sp1_ok_c   = in_win(dur, SP1_MIN, SP1_MAX);
    assign timeout_c  = (dur >= TIMEOUT);
    assign last_bit_c = (bit_cnt == LAST_BIT);
    assign shreg_nx_c = {shreg[CODE_W-2:0], sp1_ok_c};
    assign inv_ok_c   = !CHECK_INV ||
                        ((shreg_nx_c[31:24] == ~shreg_nx_c[23:16]) &&
                         (shreg_nx_c[15:8]  == ~shreg_nx_c[7:0]));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state: an edge always wins over a coincident timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (fall_q) state_nx = LEAD_MARK;
            LEAD_MARK:   if (rise_q) state_nx = lead_ok_c ? LEAD_SPACE : IDLE;
                         else if (timeout_c) state_nx = IDLE;
            LEAD_SPACE:  if (fall_q) state_nx = dsp_ok_c ? BIT_MARK :
                                                rsp_ok_c ? REPEAT_MARK : IDLE;
                         else if (timeout_c) state_nx = IDLE;
            BIT_MARK:    if (rise_q) state_nx = mark_ok_c ? BIT_SPACE : IDLE;
                         else if (timeout_c) state_nx = IDLE;
            BIT_SPACE:   if (fall_q) begin
                             if (sp0_ok_c || sp1_ok_c) state_nx = last_bit_c ? STOP_MARK : BIT_MARK;
                             else                      state_nx = IDLE;
                         end else if (timeout_c) state_nx = IDLE;
            STOP_MARK:   if (rise_q || timeout_c) state_nx = IDLE;
            REPEAT_MARK: if (rise_q || timeout_c) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        shift_c    = 1'b0;
        clr_bits_c = 1'b0;
        valid_c    = 1'b0;
        repeat_c   = 1'b0;
        error_c    = 1'b0;
        case (state)
            LEAD_SPACE: begin
                clr_bits_c = fall_q && dsp_ok_c;
                error_c    = fall_q ? (!dsp_ok_c && !rsp_ok_c) : timeout_c;
            end
            BIT_MARK:
                error_c = rise_q ? !mark_ok_c : timeout_c;
            BIT_SPACE: begin
                shift_c = fall_q && (sp0_ok_c || sp1_ok_c);
                valid_c = shift_c && last_bit_c && inv_ok_c;
                error_c = fall_q ? (!shift_c || (last_bit_c && !inv_ok_c)) : timeout_c;
            end
            REPEAT_MARK: begin
                repeat_c = rise_q && mark_ok_c && have_code;
                error_c  = rise_q ? !mark_ok_c : timeout_c;
            end
            default: ;
        endcase
    end

    // Shift register, bit counter, committed code and output pulses
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            ir_out     <= '0;
            have_code  <= 1'b0;
            valid_out  <= 1'b0;
            repeat_out <= 1'b0;
            error_out  <= 1'b0;
        end else begin
            valid_out  <= valid_c;
            repeat_out <= repeat_c;
            error_out  <= error_c;
            if (clr_bits_c)                  bit_cnt <= '0;
            else if (shift_c && !last_bit_c) bit_cnt <= bit_cnt + BIT_W'(1);
            if (shift_c) shreg <= shreg_nx_c;
            if (valid_c) begin
                ir_out    <= shreg_nx_c;
                have_code <= 1'b1;
            end
        end
    end

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Decodes the NEC infrared remote protocol from the demodulated IR receiver pin into a 32-bit code word. It is the producer of the `ir_in` code that the display and menu logic compare against, for example `32'h20DF_5BA4`. It sits between the board IR pin and the game/display control path, in the pixel-clock domain. It also flags repeat frames and malformed frames.

## Interface
Parameters:
- `CLK_PER_US`, default 74: clock cycles per microsecond tick.
- `FILT_CYCLES`, default 8: consecutive stable samples required before the filtered level changes.
- `CHECK_INV`, default 1: when 1, byte 0 must equal the complement of byte 1, and byte 2 must equal the complement of byte 3, or the frame is an error.

Ports:
- `clk_in`  input  1: system clock.
- `rst_in`  input  1: reset, asynchronous, active-low.
- `ir_raw_in`  input  1: raw IR receiver output, asynchronous to `clk_in`; low = carrier burst ("mark"), high = idle/space.
- `ir_out`  output  32: last valid code; first received bit lands at bit 31.
- `valid_out`  output  1: one-cycle pulse when `ir_out` is updated.
- `repeat_out`  output  1: one-cycle pulse on a valid NEC repeat frame.
- `error_out`  output  1: one-cycle pulse on a malformed frame.

## Operation
- **Input conditioning**
  - 2-FF synchronizer on `ir_raw_in`.
  - Glitch filter: the filtered level `filt` takes the synchronized value only after it differs from `filt` for `FILT_CYCLES` consecutive cycles.
  - An edge is `filt` changing.
- **Duration measurement**
  - A prescaler produces a µs tick every `CLK_PER_US` cycles.
  - A 14-bit µs counter `dur` saturates at 16383.
  - Both the prescaler and `dur` clear on every filtered edge.
- **Windows** (µs, inclusive):
  - leader mark 8000–10000
  - data leader space 3500–5500
  - repeat leader space 1750–2750
  - bit mark 400–750
  - bit space 0: 400–750
  - bit space 1: 1400–1950
- **FSM states:** IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REPEAT_MARK.
  - **IDLE:** falling edge → LEAD_MARK.
  - **LEAD_MARK:** rising edge with `dur` in the leader window → LEAD_SPACE. Otherwise → IDLE silently (treated as noise, no error).
  - **LEAD_SPACE:** falling edge with data space → BIT_MARK, `bit_cnt`=0. Repeat space → REPEAT_MARK. Otherwise error, → IDLE.
  - **BIT_MARK:** rising edge with bit mark in window → BIT_SPACE. Otherwise error, → IDLE.
  - **BIT_SPACE:** falling edge classifies the bit and shifts it into `shreg` (shift left, new bit at bit 0). Out-of-window space is an error, → IDLE.
    - If `bit_cnt` < 31: `bit_cnt`++, → BIT_MARK.
    - If `bit_cnt` = 31: commit, → STOP_MARK.
  - **Commit:**
    - Inverse check passes (or `CHECK_INV`=0): `ir_out` ← `shreg`, `valid_out` pulse, `have_code` ← 1.
    - Inverse check fails: `error_out` pulse, `ir_out` unchanged.
  - **STOP_MARK:** rising edge or timeout → IDLE; no check, no error.
  - **REPEAT_MARK:** rising edge with bit mark in window and `have_code`=1 → `repeat_out` pulse, → IDLE.
    - Bad mark → error, → IDLE.
    - Good mark with `have_code`=0 → IDLE silently.
- **Timeout:** `dur` reaching 12000 in LEAD_SPACE, BIT_MARK, BIT_SPACE or REPEAT_MARK → error, → IDLE.
  - In LEAD_MARK a timeout → IDLE silently.
  - In STOP_MARK a timeout → IDLE silently.
- **Priority:** an edge arriving on the same cycle as a timeout takes precedence over the timeout.
- **Mutual exclusion:** at most one of `valid_out`, `repeat_out`, `error_out` is high in any cycle.
- **Data retention:** `ir_out` holds its value through repeats, errors and idle. It changes only on a valid commit or reset.
- **`have_code`:** cleared only by reset.

## Timing
- **Reset values:**
  - `ir_out`=0; `valid_out`, `repeat_out`, `error_out`=0.
  - State IDLE; `have_code`=0.
  - Synchronizer and `filt`=1; `dur`, prescaler and `bit_cnt`=0.
- **Reset assert:** takes effect immediately (asynchronous), including mid-frame.
- **After reset release:** a partially received frame is ignored until the next leader.
- **Latency:** the raw edge that ends a frame (the falling edge starting the stop mark, or the rising edge ending the repeat mark) to the output pulse is exactly `FILT_CYCLES`+4 cycles:
  - 2 cycles synchronizer
  - `FILT_CYCLES` cycles filter
  - 1 cycle edge detect
  - 1 cycle registered output
- **Output behaviour:** `ir_out` updates on the same cycle `valid_out` is high. All outputs are registered.
- **Measurement resolution:** duration measurement is accurate to ±1 µs.

## Test plan
- **Valid frame:** `CLK_PER_US`=4, `FILT_CYCLES`=2. Send NEC frame 0x20DF5BA4 with nominal timing (9000/4500, 560/560 or 560/1690) → a single `valid_out` pulse 6 cycles after the stop-mark falling edge, `ir_out`=32'h20DF5BA4, no error.
- **Repeat:** after the valid frame, send repeat (9000/2250/560) → `repeat_out` pulse, `ir_out` still 32'h20DF5BA4. Repeat sent right after reset → no pulse of any kind.
- **Inverse check:** frame 0x20DF5BA5 with `CHECK_INV`=1 → `error_out` pulse, `ir_out` unchanged. Same frame with `CHECK_INV`=0 → `valid_out`, `ir_out`=32'h20DF5BA5.
- **Glitches and noise:** 1-cycle low glitches injected throughout a frame → decoded as clean. A 300 µs isolated low pulse in IDLE → no output pulse.
- **Out-of-window and timeout:** bit space of 1100 µs at bit 10 → `error_out`, return to IDLE, and the next good frame decodes. Line held high 13000 µs after the leader space → `error_out` once.
- **Reset mid-frame:** assert `rst_in` low at bit 20 → all outputs 0 immediately. Release, then send frame 0x20DF5AA5 → `ir_out`=32'h20DF5AA5.
